// File: rtl/mips32_pkg.sv
// Shared definitions for the MIPS32 front end: fetch FSM encoding,
// reset/bubble defaults and the PC increment helper.
package mips32_pkg;

  // FETCH: a request is outstanding at the PC.
  // HOLD:  the word was acknowledged during a stall and is parked in a buffer.
  // DROP:  a wrong-path request is still waiting for its acknowledge.
  typedef enum logic [1:0] {
    FETCH = 2'd0,
    HOLD  = 2'd1,
    DROP  = 2'd2
  } fetch_state_t;

  localparam logic [31:0] DEFAULT_RESET_PC  = 32'h0000_0000;
  localparam logic [31:0] DEFAULT_NOP_INSTR = 32'h0000_0000;

  // Increment on the word address only, so the low address bits never
  // matter and 32'hFFFF_FFFC wraps cleanly to zero.
  function automatic logic [31:0] pc_plus4(input logic [29:0] word_addr);
    return {word_addr + 30'd1, 2'b00};
  endfunction

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: load a new word, hold during a stall,
// otherwise collapse to a bubble once decode has consumed the content.
module if_id_reg
  import mips32_pkg::*;
#(
  parameter logic [31:0] NOP_INSTR = DEFAULT_NOP_INSTR
) (
  input  logic        i_clk,
  input  logic        i_s_rst,
  input  logic        i_load,
  input  logic        i_hold,
  input  logic [31:0] i_instr,
  input  logic [31:0] i_pc_4,
  output logic [31:0] o_instr,
  output logic [31:0] o_pc_4,
  output logic        o_valid
);

  logic [31:0] instr_reg;
  logic [31:0] pc_4_reg;
  logic        valid_reg;

  // Load has priority over hold; with neither, decode took the word and a bubble follows.
  always_ff @(posedge i_clk) begin
    if (i_s_rst) begin
      instr_reg <= NOP_INSTR;
      pc_4_reg  <= 32'h0000_0000;
      valid_reg <= 1'b0;
    end else if (i_load) begin
      instr_reg <= i_instr;
      pc_4_reg  <= i_pc_4;
      valid_reg <= 1'b1;
    end else if (!i_hold) begin
      instr_reg <= NOP_INSTR;
      valid_reg <= 1'b0;
    end
  end

  assign o_instr = instr_reg;
  assign o_pc_4  = pc_4_reg;
  assign o_valid = valid_reg;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC register, fetch handshake FSM with a one-word
// stall buffer and a redirect register for draining wrong-path requests.
module fetch_stage
  import mips32_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = DEFAULT_RESET_PC,
  parameter logic [31:0] NOP_INSTR = DEFAULT_NOP_INSTR
) (
  input  logic        i_clk,
  input  logic        i_s_rst,
  input  logic [31:0] i_NextPC,
  input  logic        i_stall,
  input  logic        i_flush,
  output logic [31:0] o_PC,
  output logic        o_imem_req,
  output logic [31:0] o_imem_addr,
  input  logic        i_imem_ack,
  input  logic [31:0] i_imem_rdata,
  output logic [31:0] o_instr_dec,
  output logic [31:0] o_PC_4_dec,
  output logic        o_valid_dec,
  output logic        o_fetch_busy
);

  fetch_state_t state_reg;
  logic [31:0]  pc_reg;
  logic [31:0]  redirect_reg;
  logic [31:0]  buf_instr_reg;
  logic [31:0]  buf_pc_4_reg;

  logic [31:0]  pc_4;
  logic         ifid_load;
  logic         ifid_hold;
  logic [31:0]  ifid_instr;
  logic [31:0]  ifid_pc_4;

  assign pc_4 = pc_plus4(pc_reg[31:2]);
  assign o_PC = pc_reg;

  // The PC is left untouched while a wrong-path request drains, so it is
  // also the original request address in DROP and the address stays stable.
  assign o_imem_addr  = {pc_reg[31:2], 2'b00};
  assign o_imem_req   = !i_s_rst && (state_reg != HOLD);
  assign o_fetch_busy = ((state_reg == FETCH) && !i_imem_ack) || (state_reg == DROP);

  // IF/ID control: a flush forces a bubble; otherwise load fresh or buffered words, or hold on stall.
  always_comb begin
    ifid_load  = 1'b0;
    ifid_hold  = 1'b0;
    ifid_instr = i_imem_rdata;
    ifid_pc_4  = pc_4;
    if (!i_flush) begin
      case (state_reg)
        FETCH: begin
          if (i_imem_ack && !i_stall) begin
            ifid_load = 1'b1;
          end else begin
            ifid_hold = i_stall;
          end
        end
        HOLD: begin
          if (!i_stall) begin
            ifid_load  = 1'b1;
            ifid_instr = buf_instr_reg;
            ifid_pc_4  = buf_pc_4_reg;
          end else begin
            ifid_hold = 1'b1;
          end
        end
        default: ifid_hold = i_stall;
      endcase
    end
  end

  // Fetch FSM with PC, stall buffer and redirect register; flush outranks stall everywhere.
  always_ff @(posedge i_clk) begin
    if (i_s_rst) begin
      state_reg     <= FETCH;
      pc_reg        <= RESET_PC;
      redirect_reg  <= 32'h0000_0000;
      buf_instr_reg <= 32'h0000_0000;
      buf_pc_4_reg  <= 32'h0000_0000;
    end else begin
      case (state_reg)
        FETCH: begin
          if (i_flush) begin
            if (i_imem_ack) begin
              pc_reg <= i_NextPC;
            end else begin
              redirect_reg <= i_NextPC;
              state_reg    <= DROP;
            end
          end else if (i_imem_ack) begin
            if (i_stall) begin
              buf_instr_reg <= i_imem_rdata;
              buf_pc_4_reg  <= pc_4;
              state_reg     <= HOLD;
            end else begin
              pc_reg <= i_NextPC;
            end
          end
        end
        HOLD: begin
          if (i_flush || !i_stall) begin
            pc_reg    <= i_NextPC;
            state_reg <= FETCH;
          end
        end
        DROP: begin
          if (i_flush) begin
            redirect_reg <= i_NextPC;
            if (i_imem_ack) begin
              pc_reg    <= i_NextPC;
              state_reg <= FETCH;
            end
          end else if (i_imem_ack) begin
            pc_reg    <= redirect_reg;
            state_reg <= FETCH;
          end
        end
        default: state_reg <= FETCH;
      endcase
    end
  end

  if_id_reg #(
    .NOP_INSTR(NOP_INSTR)
  ) u_if_id_reg (
    .i_clk   (i_clk),
    .i_s_rst (i_s_rst),
    .i_load  (ifid_load),
    .i_hold  (ifid_hold),
    .i_instr (ifid_instr),
    .i_pc_4  (ifid_pc_4),
    .o_instr (o_instr_dec),
    .o_pc_4  (o_PC_4_dec),
    .o_valid (o_valid_dec)
  );

endmodule

// File: tb/tb_fetch_stage.sv
// Directed testbench for fetch_stage: hand-computed expectations for
// streaming, stall buffering, flush draining, reset and PC wrap.
module tb_fetch_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk;
  logic        srst;
  logic [31:0] next_pc;
  logic        stall;
  logic        flush;
  logic [31:0] pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] instr_dec;
  logic [31:0] pc_4_dec;
  logic        valid_dec;
  logic        fetch_busy;

  int total = 0;
  int bad   = 0;

  fetch_stage #(
    .RESET_PC (32'h0000_0000),
    .NOP_INSTR(NOP)
  ) dut (
    .i_clk        (clk),
    .i_s_rst      (srst),
    .i_NextPC     (next_pc),
    .i_stall      (stall),
    .i_flush      (flush),
    .o_PC         (pc),
    .o_imem_req   (imem_req),
    .o_imem_addr  (imem_addr),
    .i_imem_ack   (imem_ack),
    .i_imem_rdata (imem_rdata),
    .o_instr_dec  (instr_dec),
    .o_PC_4_dec   (pc_4_dec),
    .o_valid_dec  (valid_dec),
    .o_fetch_busy (fetch_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end else begin
      $display("ok   %s: %h", tag, obs);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    srst = 1'b1; next_pc = 32'h0; stall = 1'b0; flush = 1'b0;
    imem_ack = 1'b0; imem_rdata = 32'h0;
    cyc();
    cyc();
    check_val("rst_req", {31'b0, imem_req}, 32'd0);
    check_val("rst_valid", {31'b0, valid_dec}, 32'd0);
    check_val("rst_instr", instr_dec, NOP);
    check_val("rst_pc4", pc_4_dec, 32'h0);
    check_val("rst_pc", pc, 32'h0);

    // Streaming: one instruction per cycle, NextPC = PC + 4
    srst = 1'b0;
    #1;
    check_val("first_req", {31'b0, imem_req}, 32'd1);
    for (int k = 0; k < 4; k++) begin
      check_val("seq_addr", imem_addr, 32'(4 * k));
      imem_ack = 1'b1;
      imem_rdata = 32'h1000 + 32'(k);
      next_pc = 32'(4 * k + 4);
      #1;
      check_val("seq_busy", {31'b0, fetch_busy}, 32'd0);
      cyc();
      check_val("seq_valid", {31'b0, valid_dec}, 32'd1);
      check_val("seq_pc4", pc_4_dec, 32'(4 * k + 4));
      check_val("seq_instr", instr_dec, 32'h1000 + 32'(k));
    end

    // Ack at 0x10 while stalled, then three held cycles
    check_val("hold_pc", pc, 32'h10);
    stall = 1'b1; imem_ack = 1'b1; imem_rdata = 32'hAAAA_0010; next_pc = 32'h14;
    cyc();
    for (int j = 0; j < 3; j++) begin
      imem_ack = 1'b0; imem_rdata = 32'hBAD0_BAD0;
      #1;
      check_val("hold_req", {31'b0, imem_req}, 32'd0);
      check_val("hold_instr", instr_dec, 32'h1003);
      check_val("hold_valid", {31'b0, valid_dec}, 32'd1);
      cyc();
    end
    stall = 1'b0; next_pc = 32'h14;
    cyc();
    check_val("rel_instr", instr_dec, 32'hAAAA_0010);
    check_val("rel_pc4", pc_4_dec, 32'h14);
    check_val("rel_pc", pc, 32'h14);

    // Walk up to 0x20
    for (int a = 32'h14; a < 32'h20; a += 4) begin
      imem_ack = 1'b1; imem_rdata = 32'h2000 | 32'(a); next_pc = 32'(a + 4);
      cyc();
    end

    // Flush to 0x40 while request to 0x20 waits two cycles
    imem_ack = 1'b0; flush = 1'b1; next_pc = 32'h40;
    #1;
    check_val("fl_busy", {31'b0, fetch_busy}, 32'd1);
    cyc();
    flush = 1'b0; next_pc = 32'h0000_099C;
    #1;
    check_val("drop_addr1", imem_addr, 32'h20);
    check_val("drop_req", {31'b0, imem_req}, 32'd1);
    check_val("drop_valid", {31'b0, valid_dec}, 32'd0);
    check_val("drop_instr", instr_dec, NOP);
    cyc();
    check_val("drop_addr2", imem_addr, 32'h20);
    imem_ack = 1'b1; imem_rdata = 32'hBAD0_0020;
    #1;
    check_val("drop_busy", {31'b0, fetch_busy}, 32'd1);
    cyc();
    check_val("redir_addr", imem_addr, 32'h40);
    check_val("redir_valid", {31'b0, valid_dec}, 32'd0);
    check_val("redir_instr", instr_dec, NOP);
    imem_ack = 1'b1; imem_rdata = 32'h0000_4040; next_pc = 32'h44;
    cyc();
    check_val("tgt_instr", instr_dec, 32'h0000_4040);
    check_val("tgt_pc4", pc_4_dec, 32'h44);

    // Flush and stall together while in HOLD
    stall = 1'b1; imem_ack = 1'b1; imem_rdata = 32'h5555_5555; next_pc = 32'h48;
    cyc();
    imem_ack = 1'b0; flush = 1'b1; next_pc = 32'h80;
    cyc();
    flush = 1'b0; stall = 1'b0;
    #1;
    check_val("hfl_addr", imem_addr, 32'h80);
    check_val("hfl_req", {31'b0, imem_req}, 32'd1);
    check_val("hfl_valid", {31'b0, valid_dec}, 32'd0);

    // Flush in DROP with ack in the same cycle takes the newest target
    flush = 1'b1; next_pc = 32'h100;
    cyc();
    imem_ack = 1'b1; imem_rdata = 32'hBAD0_0080; next_pc = 32'h200;
    cyc();
    flush = 1'b0; imem_ack = 1'b0;
    #1;
    check_val("dfl_addr", imem_addr, 32'h200);

    // Reset while draining with an ack in the reset cycle
    flush = 1'b1; next_pc = 32'h300;
    cyc();
    flush = 1'b0; srst = 1'b1; imem_ack = 1'b1; imem_rdata = 32'hBAD0_0200;
    #1;
    check_val("rstd_req", {31'b0, imem_req}, 32'd0);
    cyc();
    srst = 1'b0; imem_ack = 1'b0;
    #1;
    check_val("rstd_addr", imem_addr, 32'h0);
    check_val("rstd_valid", {31'b0, valid_dec}, 32'd0);
    check_val("rstd_instr", instr_dec, NOP);
    check_val("rstd_busy", {31'b0, fetch_busy}, 32'd1);

    // PC wrap at the top of the address space, unaligned NextPC
    imem_ack = 1'b1; imem_rdata = 32'h0000_6000; next_pc = 32'hFFFF_FFFF;
    cyc();
    check_val("wrap_addr", imem_addr, 32'hFFFF_FFFC);
    check_val("wrap_pc4a", pc_4_dec, 32'h4);
    imem_rdata = 32'h0000_7777; next_pc = 32'h0;
    cyc();
    check_val("wrap_pc4", pc_4_dec, 32'h0);
    check_val("wrap_instr", instr_dec, 32'h0000_7777);
    check_val("wrap_next", imem_addr, 32'h0);

    // No ack, no stall: decode consumes and a bubble follows
    imem_ack = 1'b0;
    cyc();
    check_val("bub_valid", {31'b0, valid_dec}, 32'd0);
    check_val("bub_instr", instr_dec, NOP);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, SHALL set the first fetch address after reset.
REQ-002 Parameter NOP_INSTR, default 32'h0000_0000, SHALL be the instruction presented while IF/ID holds a bubble.
REQ-003 i_clk  in  1  sole clock; all state SHALL update on its rising edge.
REQ-004 i_s_rst  in  1  reset, synchronous and active-high.
REQ-005 i_NextPC  in  32  next/redirect PC from next-PC logic.
REQ-006 i_stall  in  1  hazard-unit stall of PC and IF/ID.
REQ-007 i_flush  in  1  redirect; fetch in flight and IF/ID content are wrong-path; target is i_NextPC.
REQ-008 o_PC  out  32  current PC register, fed back to next-PC logic.
REQ-009 o_imem_req  out  1  instruction-memory request.
REQ-010 o_imem_addr  out  32  request address, word aligned.
REQ-011 i_imem_ack  in  1  one-cycle acknowledge; i_imem_rdata valid in the same cycle.
REQ-012 i_imem_rdata  in  32  fetched instruction.
REQ-013 o_instr_dec  out  32  IF/ID instruction.
REQ-014 o_PC_4_dec  out  32  IF/ID PC+4.
REQ-015 o_valid_dec  out  1  IF/ID holds a real instruction.
REQ-016 o_fetch_busy  out  1  stall request to hazard unit while a fetch is outstanding.

Function
REQ-017 FSM states SHALL be FETCH (request outstanding), HOLD (ack taken while stalled, word buffered) and DROP (wrong-path request draining).
REQ-018 o_imem_req SHALL be 1 in FETCH and DROP and 0 in HOLD.
REQ-019 o_imem_addr SHALL be held stable from request until ack (handshake rule): PC in FETCH, the original request address in DROP.
REQ-020 o_imem_addr[1:0] SHALL always be 2'b00, with i_NextPC[1:0] ignored.
REQ-021 FETCH, ack, no stall, no flush: IF/ID <= {rdata, PC+4, valid=1}; PC <= i_NextPC; stay FETCH.
REQ-022 FETCH, ack, stall, no flush: buffer rdata and PC+4; IF/ID and PC unchanged; go to HOLD.
REQ-023 HOLD, no stall, no flush: IF/ID <= buffer with valid=1; PC <= i_NextPC; go to FETCH.
REQ-024 FETCH, no ack: PC and IF/ID SHALL be unchanged, except that valid is cleared per REQ-026/027.
REQ-025 Flush SHALL take priority over stall in every state.
REQ-026 Flush in FETCH with ack: PC <= i_NextPC; valid <= 0; IF/ID instruction <= NOP_INSTR; stay FETCH.
REQ-027 Flush in FETCH without ack: latch i_NextPC into a redirect register; valid <= 0; IF/ID instruction <= NOP_INSTR; go to DROP.
REQ-028 DROP, ack: discard rdata; PC <= redirect register; go to FETCH.
REQ-029 Flush in DROP SHALL overwrite the redirect register, and an ack in the same cycle SHALL use the new i_NextPC.
REQ-030 Flush in HOLD: discard buffer; PC <= i_NextPC; valid <= 0; go to FETCH.
REQ-031 Consumption: while i_stall=0 and no new word is loaded, IF/ID SHALL load a bubble (valid=0, NOP_INSTR).
REQ-032 Consumption: while i_stall=1, IF/ID SHALL hold its content.
REQ-033 o_fetch_busy SHALL be (FETCH and not ack) or DROP.
REQ-034 PC+4 SHALL be computed as {PC[31:2]+1, 2'b00}, wrapping 32'hFFFF_FFFC to 32'h0000_0000.
REQ-035 Minimum latency SHALL be one instruction per cycle with single-cycle acks; request-to-IF/ID latency SHALL be one edge.

Reset
REQ-036 With i_s_rst=1 at an edge, the block SHALL load PC=RESET_PC, state=FETCH, IF/ID={NOP_INSTR, 0, valid=0}, and clear the buffer and redirect register.
REQ-037 o_imem_req SHALL be 0 while i_s_rst=1.
REQ-038 Reset mid-request SHALL abandon the request, and an ack in the reset cycle SHALL be ignored.
REQ-039 The first request after reset SHALL go to RESET_PC in the first cycle with i_s_rst=0.

Structure
REQ-040 FSM state encoding, RESET_PC default and NOP_INSTR SHALL live in the shared package mips32_pkg.
REQ-041 The IF/ID register (load/bubble/hold) SHALL be the sub-module if_id_reg; the FSM, PC, buffer and redirect register SHALL stay in fetch_stage.

Verification
REQ-042 Reset release, ack every cycle, NextPC=PC+4: addresses 0,4,8; o_valid_dec=1 from the second edge; o_PC_4_dec=4,8,12.
REQ-043 Ack at PC=0x10 with i_stall=1 for 3 cycles: HOLD for 3 cycles, req=0, IF/ID unchanged; on release o_instr_dec=buffered word and PC=i_NextPC.
REQ-044 Flush with target 0x40 while the request to 0x20 waits 2 cycles: o_imem_addr stays 0x20 until ack; o_valid_dec=0; next request goes to 0x40; rdata for 0x20 never reaches IF/ID.
REQ-045 Flush and stall in the same cycle in HOLD: flush wins; next address is i_NextPC; o_valid_dec=0.
REQ-046 i_s_rst asserted while DROP with an ack in the same cycle: next request goes to RESET_PC; IF/ID is a bubble.
REQ-047 PC=32'hFFFF_FFFC with ack: o_PC_4_dec=32'h0000_0000.
